// File: rtl/multiport_memory.sv
// rtl/multiport_memory.sv - Round-robin shared word memory with pipelined per-port responses
// Optional request statistics are enabled by defining MULTIPORT_MEMORY_PERF_CNT_EN.
module multiport_memory #(
   parameter int    ADDR_WIDTH   = 16,
   parameter int    DATA_WIDTH   = 64,
   parameter int    MEM_SIZE     = 65536,
   parameter int    NUM_PORTS    = 2,
   parameter int    READ_LATENCY = 2,
   parameter string MEM_FILE     = ""
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_PORTS-1:0]                  req_valid,
   input  logic [NUM_PORTS-1:0]                  req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]       req_wdata,
   input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   req_wstrb,
   output logic [NUM_PORTS-1:0]                  req_ready,
   output logic [NUM_PORTS-1:0]                  resp_valid,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]       resp_rdata,
   output logic [NUM_PORTS-1:0]                  resp_err
`ifdef MULTIPORT_MEMORY_PERF_CNT_EN
   ,
   output logic [31:0]                           stat_reads,
   output logic [31:0]                           stat_writes,
   output logic [31:0]                           stat_errors
`endif
);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int OFF   = $clog2(NB);
   localparam int DEPTH = MEM_SIZE / NB;
   localparam int MIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0]         ptr;
   logic [PW-1:0]         gnt_idx;
   logic                  accept;
   int                    scan_p;

   logic                  acc_write;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [DATA_WIDTH-1:0] acc_wdata;
   logic [NB-1:0]         acc_wstrb;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [MIW-1:0]        mem_idx;
   logic                  acc_err;

   logic [READ_LATENCY-1:0] pipe_valid;
   logic [READ_LATENCY-1:0] pipe_err;
   logic [PW-1:0]           pipe_port [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

   // Grant the first valid port at or after the pointer; nothing is granted while in reset.
   always_comb begin
      req_ready = '0;
      gnt_idx   = '0;
      accept    = 1'b0;
      scan_p    = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         scan_p = (int'(ptr) + k) % NUM_PORTS;
         if (reset && !accept && req_valid[scan_p]) begin
            accept            = 1'b1;
            gnt_idx           = PW'(scan_p);
            req_ready[scan_p] = 1'b1;
         end
      end
   end

   assign acc_write = req_write[gnt_idx];
   assign acc_addr  = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign acc_wdata = req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign acc_wstrb = req_wstrb[int'(gnt_idx)*NB +: NB];
   assign word_idx  = acc_addr >> OFF;
   assign mem_idx   = word_idx[MIW-1:0];
   assign acc_err   = (|(acc_addr & ADDR_WIDTH'(NB - 1))) || (32'(word_idx) >= 32'(DEPTH));

   always_ff @(posedge clk) begin
      if (accept && acc_write && !acc_err) begin
         for (int b = 0; b < NB; b++) begin
            if (acc_wstrb[b]) mem[mem_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr        <= '0;
         pipe_valid <= '0;
         pipe_err   <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_port[i] <= '0;
            pipe_data[i] <= '0;
         end
         resp_valid <= '0;
         resp_err   <= '0;
         resp_rdata <= '0;
      end else begin
         if (accept) ptr <= (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;

         // Stage 0 captures the array contents as they stood at the acceptance edge.
         pipe_valid[0] <= accept;
         pipe_err[0]   <= accept && acc_err;
         pipe_port[0]  <= gnt_idx;
         pipe_data[0]  <= (accept && !acc_write && !acc_err) ? mem[mem_idx] : '0;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
            pipe_port[i]  <= pipe_port[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end

         resp_valid <= '0;
         resp_err   <= '0;
         resp_rdata <= '0;
         if (pipe_valid[READ_LATENCY-1]) begin
            resp_valid[pipe_port[READ_LATENCY-1]] <= 1'b1;
            resp_err[pipe_port[READ_LATENCY-1]]   <= pipe_err[READ_LATENCY-1];
            resp_rdata[int'(pipe_port[READ_LATENCY-1])*DATA_WIDTH +: DATA_WIDTH] <=
               pipe_data[READ_LATENCY-1];
         end
      end
   end

`ifdef MULTIPORT_MEMORY_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_reads  <= '0;
         stat_writes <= '0;
         stat_errors <= '0;
      end else if (accept) begin
         if (acc_err) begin
            if (stat_errors != '1) stat_errors <= stat_errors + 1'b1;
         end else if (acc_write) begin
            if (stat_writes != '1) stat_writes <= stat_writes + 1'b1;
         end else begin
            if (stat_reads != '1) stat_reads <= stat_reads + 1'b1;
         end
      end
   end
`else
   // Statistics compiled out: no counter state exists in this build.
`endif

endmodule

// File: tb/tb_multiport_memory.sv
// tb/tb_multiport_memory.sv - Randomized and directed checks of multiport_memory against a queue-based model
// Counter checks are included when MULTIPORT_MEMORY_PERF_CNT_EN is defined.
module tb_multiport_memory;
   localparam int AW    = 16;
   localparam int DW    = 64;
   localparam int MS    = 32768;
   localparam int NP    = 2;
   localparam int L     = 2;
   localparam int DEPTH = MS / 8;

   logic                clk;
   logic                reset;
   logic [NP-1:0]       req_valid;
   logic [NP-1:0]       req_write;
   logic [NP*AW-1:0]    req_addr;
   logic [NP*DW-1:0]    req_wdata;
   logic [NP*8-1:0]     req_wstrb;
   logic [NP-1:0]       req_ready;
   logic [NP-1:0]       resp_valid;
   logic [NP*DW-1:0]    resp_rdata;
   logic [NP-1:0]       resp_err;
`ifdef MULTIPORT_MEMORY_PERF_CNT_EN
   logic [31:0]         stat_reads;
   logic [31:0]         stat_writes;
   logic [31:0]         stat_errors;
`endif

   multiport_memory #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS),
      .NUM_PORTS(NP), .READ_LATENCY(L), .MEM_FILE("")
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
`ifdef MULTIPORT_MEMORY_PERF_CNT_EN
      , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_errors(stat_errors)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          port;
      logic [63:0] data;
      logic        err;
      int          due;
   } resp_t;

   logic [63:0] mdl_mem [DEPTH];
   resp_t       exp_q [$];
   int          mdl_ptr;
   int          cyc;
   int          last_g;
   logic [63:0] last_rdata [NP];
   logic        last_err [NP];
   int          resp_cnt [NP];
   int          n_chk;
   int          n_fail;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic issue(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [7:0] s);
      req_valid[p]           = 1'b1;
      req_write[p]           = w;
      req_addr[p*AW +: AW]   = a;
      req_wdata[p*DW +: DW]  = d;
      req_wstrb[p*8 +: 8]    = s;
   endtask

   task automatic mdl_accept(input int g);
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [7:0]    s;
      int            idx;
      resp_t         r;
      a = req_addr[g*AW +: AW];
      d = req_wdata[g*DW +: DW];
      s = req_wstrb[g*8 +: 8];
      idx    = int'(a) / 8;
      r.port = g;
      r.due  = cyc + L;
      r.data = '0;
      r.err  = (int'(a) % 8 != 0) || (idx >= DEPTH);
      if (!r.err) begin
         if (req_write[g]) begin
            for (int b = 0; b < 8; b++)
               if (s[b]) mdl_mem[idx][b*8 +: 8] = d[b*8 +: 8];
         end else begin
            r.data = mdl_mem[idx];
         end
      end
      exp_q.push_back(r);
   endtask

   // One clock: check the grant, advance the model, then check this cycle's responses.
   task automatic tick();
      int            g;
      logic [NP-1:0] er;
      logic [NP-1:0] ev;
      resp_t         r;
      #1;
      g = -1;
      if (reset) begin
         for (int k = 0; k < NP; k++)
            if (g < 0 && req_valid[(mdl_ptr + k) % NP]) g = (mdl_ptr + k) % NP;
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      @(posedge clk);
      cyc++;
      last_g = g;
      if (g >= 0) begin
         mdl_accept(g);
         mdl_ptr = (g + 1) % NP;
      end
      #1;
      if (g >= 0) req_valid[g] = 1'b0;
      ev = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         r = exp_q.pop_front();
         ev[r.port] = 1'b1;
      end
      chk("resp_valid", 64'(resp_valid), 64'(ev));
      if (ev != '0) begin
         chk("resp_rdata", resp_rdata[r.port*DW +: DW], r.data);
         chk("resp_err", 64'(resp_err[r.port]), 64'(r.err));
         last_rdata[r.port] = resp_rdata[r.port*DW +: DW];
         last_err[r.port]   = resp_err[r.port];
         resp_cnt[r.port]++;
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((req_valid != '0 || exp_q.size() != 0) && n < 100) begin
         tick();
         n++;
      end
      chk(tag, 64'(n < 100), 64'd1);
   endtask

   task automatic reset_pulse();
      reset = 1'b0;
      exp_q.delete();
      mdl_ptr = 0;
      repeat (3) tick();
      reset = 1'b1;
   endtask

   initial begin
      int gseq [$];
      int issued [NP];
      n_chk = 0; n_fail = 0; cyc = 0; mdl_ptr = 0; last_g = -1;
      for (int p = 0; p < NP; p++) begin
         resp_cnt[p] = 0; last_rdata[p] = '0; last_err[p] = 1'b0; issued[p] = 0;
      end
      reset = 1'b0;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_err", 64'(resp_err), 64'd0);
      chk("rst_rdata0", resp_rdata[0 +: DW], 64'd0);
      chk("rst_rdata1", resp_rdata[DW +: DW], 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
`ifdef MULTIPORT_MEMORY_PERF_CNT_EN
      chk("rst_stat_reads", 64'(stat_reads), 64'd0);
`endif
      reset = 1'b1;

      // Fully initialise words 0..127 and the top word so every later read is defined.
      for (int w = 0; w < 128; w++) begin
         issue(w % 2, 1'b1, AW'(w * 8), {$urandom, $urandom}, 8'hFF);
         tick();
      end
      issue(1, 1'b1, 16'h7FF8, 64'h0123456789ABCDEF, 8'hFF);
      drain("drain_init");

      issue(0, 1'b1, 16'h0010, 64'hDEADBEEFCAFEBABE, 8'hFF);
      tick();
      issue(0, 1'b0, 16'h0010, '0, 8'h00);
      drain("drain_basic");
      chk("basic_rdata", last_rdata[0], 64'hDEADBEEFCAFEBABE);
      chk("basic_err", 64'(last_err[0]), 64'd0);

      issue(0, 1'b1, 16'h0100, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
      tick();
      issue(0, 1'b1, 16'h0100, 64'h1122334455667788, 8'h0F);
      tick();
      issue(0, 1'b1, 16'h0100, 64'hAAAAAAAAAAAAAAAA, 8'h00);
      tick();
      issue(0, 1'b0, 16'h0100, '0, 8'h00);
      drain("drain_strb");
      chk("strb_rdata", last_rdata[0], 64'hFFFFFFFF55667788);

      // Last grant on port 1 leaves the pointer on port 0.
      issue(1, 1'b0, 16'h0008, '0, 8'h00);
      drain("drain_pre_arb");
      resp_cnt[0] = 0; resp_cnt[1] = 0;
      for (int i = 0; i < 6; i++) begin
         for (int p = 0; p < NP; p++) begin
            if (!req_valid[p] && issued[p] < 3) begin
               issue(p, 1'b0, AW'(p * 16'h0080 + issued[p] * 8), '0, 8'h00);
               issued[p]++;
            end
         end
         tick();
         gseq.push_back(last_g);
      end
      drain("drain_arb");
      for (int i = 0; i < 6; i++) chk("arb_grant", 64'(gseq[i]), 64'(i % 2));
      chk("arb_cnt0", 64'(resp_cnt[0]), 64'd3);
      chk("arb_cnt1", 64'(resp_cnt[1]), 64'd3);

      issue(0, 1'b0, 16'h0003, '0, 8'h00);
      drain("drain_err_mis");
      chk("err_mis_flag", 64'(last_err[0]), 64'd1);
      chk("err_mis_rdata", last_rdata[0], 64'd0);
      issue(1, 1'b1, 16'hFFF8, 64'h5555555555555555, 8'hFF);
      drain("drain_err_oor");
      chk("err_oor_flag", 64'(last_err[1]), 64'd1);
      issue(1, 1'b0, 16'h7FF8, '0, 8'h00);
      drain("drain_err_top");
      chk("err_top_rdata", last_rdata[1], 64'h0123456789ABCDEF);
      chk("err_top_flag", 64'(last_err[1]), 64'd0);

      for (int i = 0; i < 300; i++) begin
         for (int p = 0; p < NP; p++) begin
            if (!req_valid[p] && $urandom_range(0, 9) < 6) begin
               int sel;
               logic [AW-1:0] a;
               sel = $urandom_range(0, 15);
               if (sel == 0)      a = AW'(16'h0200 + 8 * $urandom_range(0, 63) + $urandom_range(1, 7));
               else if (sel == 1) a = AW'(16'h8000 + 8 * $urandom_range(0, 4095));
               else               a = AW'(16'h0200 + 8 * $urandom_range(0, 63));
               issue(p, 1'($urandom), a, {$urandom, $urandom}, 8'($urandom));
            end
         end
         tick();
      end
      drain("drain_random");

      issue(0, 1'b0, 16'h0010, '0, 8'h00);
      tick();
      chk("midflight_accept", 64'(last_g), 64'd0);
      tick();
      reset_pulse();
      repeat (2) tick();
      issue(0, 1'b0, 16'h0010, '0, 8'h00);
      issue(1, 1'b0, 16'h0200, '0, 8'h00);
      tick();
      chk("post_rst_ptr", 64'(last_g), 64'd0);
      drain("drain_post_rst");
      chk("post_rst_rdata", last_rdata[0], 64'hDEADBEEFCAFEBABE);

      reset_pulse();
      for (int i = 0; i < 5; i++) begin
         issue(0, 1'b0, AW'(16'h0200 + 8 * i), '0, 8'h00);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         issue(0, 1'b1, AW'(16'h0300 + 8 * i), {$urandom, $urandom}, 8'hFF);
         tick();
      end
      issue(0, 1'b0, 16'h0005, '0, 8'h00);
      tick();
      issue(0, 1'b1, 16'h9000, '0, 8'hFF);
      drain("drain_perf");
`ifdef MULTIPORT_MEMORY_PERF_CNT_EN
      chk("stat_reads", 64'(stat_reads), 64'd5);
      chk("stat_writes", 64'(stat_writes), 64'd3);
      chk("stat_errors", 64'(stat_errors), 64'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
